// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory_stage slice
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W2   = 2'd1,
        W3   = 2'd2
    } mem_state_t;

    localparam logic [1:0] WORDS_SINGLE   = 2'd1;
    localparam logic [1:0] WORDS_PC       = 2'd2;
    localparam logic [1:0] WORDS_PC_FLAGS = 2'd3;

    localparam int NF = 2;
    localparam int CF = 1;
    localparam int ZF = 0;

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic        wb;
        logic        stack;
        logic        spop;
        logic        stack_pc;
        logic        stack_flags;
        logic [2:0]  wb_address;
        logic [31:0] data;
        logic [31:0] address;
        logic [2:0]  final_flags;
    } mem_req_t;

    function automatic logic [1:0] word_count(input logic stack, input logic stack_pc,
                                               input logic stack_flags);
        if (stack && stack_pc)
            return stack_flags ? WORDS_PC_FLAGS : WORDS_PC;
        return WORDS_SINGLE;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - EX/MEM request and MEM/WB result bundle of the memory stage
interface memory_stage_if;
    logic        MR;
    logic        MW;
    logic        WB;
    logic        SP;
    logic        SPOP;
    logic        Stack_PC;
    logic        Stack_Flags;
    logic [2:0]  WB_Address;
    logic [31:0] Data;
    logic [31:0] Address;
    logic [2:0]  Final_Flags;

    logic        Stall_Out;
    logic        WB_Out;
    logic [2:0]  WB_Address_Out;
    logic [15:0] WB_Data;
    logic [31:0] PC_From_Memory;
    logic        PC_Valid;
    logic [2:0]  Flags_From_Memory;
    logic        MEM_Stack_Flags;

    modport master (
        output MR, MW, WB, SP, SPOP, Stack_PC, Stack_Flags, WB_Address, Data, Address,
               Final_Flags,
        input  Stall_Out, WB_Out, WB_Address_Out, WB_Data, PC_From_Memory, PC_Valid,
               Flags_From_Memory, MEM_Stack_Flags
    );

    modport slave (
        input  MR, MW, WB, SP, SPOP, Stack_PC, Stack_Flags, WB_Address, Data, Address,
               Final_Flags,
        output Stall_Out, WB_Out, WB_Address_Out, WB_Data, PC_From_Memory, PC_Valid,
               Flags_From_Memory, MEM_Stack_Flags
    );
endinterface

// File: rtl/memory_stage_stack_pointer_unit.sv
// rtl/memory_stage_stack_pointer_unit.sv - stack pointer register and access address
// STACK_GUARD_EN enables overflow/underflow detection that blocks the SP update.
module stack_pointer_unit #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] addr,
    output logic              fault
);

    // push writes at SP (post-decrement), pop reads SP+1 (pre-increment)
    assign addr = pop ? sp + 1'b1 : sp;

`ifdef STACK_GUARD_EN
    assign fault = (push && sp == '0) || (pop && sp == SP_INIT);
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= SP_INIT;
        end else if (!fault) begin
            if (push)
                sp <= sp - 1'b1;
            else if (pop)
                sp <= sp + 1'b1;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: data memory, stack sequencing, MEM/WB register
// STACK_GUARD_EN adds the sticky Stack_Fault output.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
`ifdef STACK_GUARD_EN
    ,
    output logic          Stack_Fault
`endif
);

    mem_state_t        state;
    mem_req_t          live, lat, cur;
    logic [15:0]       mem [2**ADDR_W];
    logic [1:0]        n_words, k;
    logic              last_word, push, pop, fault, op_fault, fault_acc;
    logic              flags_rd, pc_hi_rd, rd_sel, mem_we;
    logic [ADDR_W-1:0] sp_addr, mem_addr, unused_sp;
    logic [15:0]       mem_wdata, mem_rdata, push_word, pc_high;
    logic              unused_addr_bits;

    always_comb begin
        live             = '0;
        live.mr          = bus.MR;
        live.mw          = bus.MW;
        live.wb          = bus.WB;
        live.stack       = bus.SP;
        live.spop        = bus.SPOP;
        live.stack_pc    = bus.Stack_PC;
        live.stack_flags = bus.Stack_Flags;
        live.wb_address  = bus.WB_Address;
        live.data        = bus.Data;
        live.address     = bus.Address;
        live.final_flags = bus.Final_Flags;
    end

    // first word is served straight from the inputs; later words from the latched copy
    assign cur       = (state == IDLE) ? live : lat;
    assign n_words   = word_count(cur.stack, cur.stack_pc, cur.stack_flags);
    assign k         = (state == IDLE) ? 2'd0 : (state == W2) ? 2'd1 : 2'd2;
    assign last_word = (k == n_words - 2'd1);
    assign bus.Stall_Out = ~last_word;

    assign push      = cur.stack & ~cur.spop;
    assign pop       = cur.stack & cur.spop;
    assign flags_rd  = pop & cur.stack_pc & cur.stack_flags & (k == 2'd0);
    assign pc_hi_rd  = pop & cur.stack_pc & (k == n_words - 2'd2);
    assign fault_acc = fault | ((state != IDLE) & op_fault);
    assign rd_sel    = cur.mr | (pop & ~cur.stack_pc);
    assign unused_addr_bits = ^cur.address[31:ADDR_W];

    stack_pointer_unit #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .sp    (unused_sp),
        .addr  (sp_addr),
        .fault (fault)
    );

    always_comb begin
        case (k)
            2'd0:    push_word = cur.data[15:0];
            2'd1:    push_word = cur.data[31:16];
            default: push_word = {13'b0, cur.final_flags};
        endcase
    end

    assign mem_addr  = cur.stack ? sp_addr : cur.address[ADDR_W-1:0];
    assign mem_wdata = push ? push_word : cur.data[15:0];
    assign mem_we    = ~rst & ((push & ~fault) | (~cur.stack & cur.mw));
    assign mem_rdata = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            lat                   <= '0;
            pc_high               <= '0;
            op_fault              <= 1'b0;
            bus.WB_Out            <= 1'b0;
            bus.WB_Address_Out    <= '0;
            bus.WB_Data           <= '0;
            bus.PC_From_Memory    <= '0;
            bus.PC_Valid          <= 1'b0;
            bus.Flags_From_Memory <= '0;
            bus.MEM_Stack_Flags   <= 1'b0;
        end else begin
            bus.PC_Valid        <= 1'b0;
            bus.MEM_Stack_Flags <= 1'b0;
            op_fault            <= fault_acc;
            if (state == IDLE)
                lat <= live;
            if (flags_rd) begin
                bus.MEM_Stack_Flags   <= 1'b1;
                bus.Flags_From_Memory <= {mem_rdata[NF], mem_rdata[CF], mem_rdata[ZF]};
            end
            if (pc_hi_rd)
                pc_high <= mem_rdata;
            if (last_word) begin
                state              <= IDLE;
                bus.WB_Out         <= cur.wb & ~fault_acc;
                bus.WB_Address_Out <= cur.wb_address;
                bus.WB_Data        <= rd_sel ? mem_rdata : cur.data[15:0];
                if (pop && cur.stack_pc) begin
                    bus.PC_Valid       <= 1'b1;
                    bus.PC_From_Memory <= {pc_high, mem_rdata};
                end
            end else begin
                state <= (state == IDLE) ? W2 : W3;
            end
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            Stack_Fault <= 1'b0;
        else if (fault)
            Stack_Fault <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized bench for memory_stage against a word-list stack model
module tb_memory_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_stage_if bus ();

`ifdef STACK_GUARD_EN
    logic stack_fault;
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    memory_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STACK_GUARD_EN
        ,
        .Stack_Fault (stack_fault)
`endif
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] mmem [4096];
    int          msp;
    logic        e_wb, e_fault;
    logic [2:0]  e_wba, e_flags;
    logic [15:0] e_wbd;
    logic [31:0] e_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic mw, input logic wb, input logic spo,
                         input logic spop, input logic spc, input logic sfl,
                         input logic [2:0] wba, input logic [31:0] data,
                         input logic [31:0] addr, input logic [2:0] ff);
        bus.MR = mr; bus.MW = mw; bus.WB = wb; bus.SP = spo; bus.SPOP = spop;
        bus.Stack_PC = spc; bus.Stack_Flags = sfl; bus.WB_Address = wba;
        bus.Data = data; bus.Address = addr; bus.Final_Flags = ff;
    endtask

    task automatic model_reset();
        msp = 12'hFFF; e_wb = 0; e_wba = 0; e_wbd = 0; e_pc = 0; e_flags = 0; e_fault = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [11:0] sp_exp;
        sp_exp = msp[11:0];
        check_eq({tag, ".wb"},    32'(bus.WB_Out), 32'(e_wb));
        check_eq({tag, ".wba"},   32'(bus.WB_Address_Out), 32'(e_wba));
        check_eq({tag, ".wbd"},   32'(bus.WB_Data), 32'(e_wbd));
        check_eq({tag, ".pc"},    bus.PC_From_Memory, e_pc);
        check_eq({tag, ".flags"}, 32'(bus.Flags_From_Memory), 32'(e_flags));
        check_eq({tag, ".sp"},    32'(dut.u_sp.sp), 32'(sp_exp));
`ifdef STACK_GUARD_EN
        check_eq({tag, ".fault"}, 32'(stack_fault), 32'(e_fault));
`endif
    endtask

    // Model works on whole operations: list of words pushed or popped, then the
    // per-cycle stall/strobe pattern that a sequence of n words must produce.
    task automatic do_op(input string tag, input logic mr, input logic mw, input logic wb,
                         input logic spo, input logic spop, input logic spc, input logic sfl,
                         input logic [2:0] wba, input logic [31:0] data,
                         input logic [31:0] addr, input logic [2:0] ff);
        int          n;
        logic [15:0] w [3];
        logic [15:0] r [3];
        logic        flt;
        int          a;
        n   = (spo && spc) ? (sfl ? 3 : 2) : 1;
        flt = 1'b0;
        a   = int'(addr[11:0]);
        w[0] = data[15:0]; w[1] = data[31:16]; w[2] = {13'b0, ff};
        r[0] = '0; r[1] = '0; r[2] = '0;
        if (spo && !spop) begin
            for (int i = 0; i < n; i++) begin
                if (GUARD && msp == 0) flt = 1'b1;
                else begin mmem[msp] = w[i]; msp = (msp - 1) & 12'hFFF; end
            end
        end else if (spo && spop) begin
            for (int i = 0; i < n; i++) begin
                r[i] = mmem[(msp + 1) & 12'hFFF];
                if (GUARD && msp == 12'hFFF) flt = 1'b1;
                else msp = (msp + 1) & 12'hFFF;
            end
        end else begin
            r[0] = mmem[a];
            if (mw) mmem[a] = data[15:0];
        end
        e_wb  = wb & ~flt;
        e_wba = wba;
        e_wbd = (mr || (spo && spop && !spc)) ? r[n-1] : data[15:0];
        if (spo && spop && spc) e_pc = {r[n-2], r[n-1]};
        if (spo && spop && spc && sfl) e_flags = r[0][2:0];
        if (flt) e_fault = 1'b1;

        @(negedge clk);
        drive(mr, mw, wb, spo, spop, spc, sfl, wba, data, addr, ff);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            #1 check_eq({tag, ".stall"}, 32'(bus.Stall_Out), 32'(c < n - 1));
            @(posedge clk);
            #1;
            check_eq({tag, ".fstb"}, 32'(bus.MEM_Stack_Flags), 32'(spo && spop && spc && sfl && c == 0));
            check_eq({tag, ".pcv"},  32'(bus.PC_Valid), 32'(spo && spop && spc && c == n - 1));
        end
        check_outputs(tag);
    endtask

    initial begin
        int          depth, kind, pa;
        logic [31:0] data, addr;
        logic [2:0]  wba, ff;
        logic        wb;

        drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 3'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        check_eq("reset.stall", 32'(bus.Stall_Out), 32'd0);
        check_eq("reset.pcv", 32'(bus.PC_Valid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            do_op("prestore", 0, 1, 0, 0, 0, 0, 0, 3'd0, $urandom(), 32'(i), 3'd0);

        do_op("store", 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'h0000_BEEF, 32'd5, 3'd0);
        do_op("load", 1, 0, 1, 0, 0, 0, 0, 3'd3, 32'd0, 32'd5, 3'd0);
        check_eq("load.beef", 32'(bus.WB_Data), 32'h0000_BEEF);

        do_op("call", 0, 0, 0, 1, 0, 1, 0, 3'd0, 32'h0001_2345, 32'd0, 3'd0);
        check_eq("call.sp", 32'(dut.u_sp.sp), 32'h0000_0FFD);
        do_op("ret", 0, 0, 0, 1, 1, 1, 0, 3'd0, 32'd0, 32'd0, 3'd0);
        check_eq("ret.pc", bus.PC_From_Memory, 32'h0001_2345);

        do_op("int", 0, 0, 0, 1, 0, 1, 1, 3'd0, 32'h0004_0ABC, 32'd0, 3'b101);
        check_eq("int.sp", 32'(dut.u_sp.sp), 32'h0000_0FFC);
        do_op("rti", 0, 0, 0, 1, 1, 1, 1, 3'd0, 32'd0, 32'd0, 3'd0);
        check_eq("rti.flags", 32'(bus.Flags_From_Memory), 32'd5);
        check_eq("rti.pc", bus.PC_From_Memory, 32'h0004_0ABC);

        for (int i = 0; i < 300; i++) begin
            depth = 12'hFFF - msp;
            kind  = $urandom_range(0, 8);
            data  = $urandom();
            addr  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
            wba   = 3'($urandom());
            ff    = 3'($urandom());
            wb    = 1'($urandom());
            if      (kind == 1) do_op("rnd.st",   0, 1, 0, 0, 0, 0, 0, wba, data, addr, ff);
            else if (kind == 2) do_op("rnd.ld",   1, 0, 1, 0, 0, 0, 0, wba, data, addr, ff);
            else if (kind == 3 && depth < 60) do_op("rnd.push", 0, 0, 0, 1, 0, 0, 0, wba, data, addr, ff);
            else if (kind == 4 && depth >= 1) do_op("rnd.pop",  0, 0, 1, 1, 1, 0, 0, wba, data, addr, ff);
            else if (kind == 5 && depth < 60) do_op("rnd.call", 0, 0, 0, 1, 0, 1, 0, wba, data, addr, ff);
            else if (kind == 6 && depth >= 2) do_op("rnd.ret",  0, 0, wb, 1, 1, 1, 0, wba, data, addr, ff);
            else if (kind == 7 && depth < 60) do_op("rnd.int",  0, 0, 0, 1, 0, 1, 1, wba, data, addr, ff);
            else if (kind == 8 && depth >= 3) do_op("rnd.rti",  0, 0, wb, 1, 1, 1, 1, wba, data, addr, ff);
            else do_op("rnd.alu", 0, 0, wb, 0, 0, 0, 0, wba, data, addr, ff);
        end

        pa = msp;
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 1, 1, 3'd0, 32'hCAFE_F00D, 32'd0, 3'b011);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 3'd0);
        mmem[pa] = 16'hF00D;
        model_reset();
        #1;
        check_outputs("midrst");
        check_eq("midrst.stall", 32'(bus.Stall_Out), 32'd0);
        check_eq("midrst.partial", 32'(dut.mem[pa]), 32'h0000_F00D);
        @(negedge clk);
        rst = 1'b0;

        do_op("wrap", 0, 0, 1, 1, 1, 0, 0, 3'd2, 32'd0, 32'd0, 3'd0);
        check_eq("wrap.sp", 32'(dut.u_sp.sp), GUARD ? 32'h0000_0FFF : 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
